// File: rtl/mcp3008_emulator_pkg.sv
// Shared definitions for the MCP3008 SPI responder: FSM states, frame geometry
// and the differential-mode clamp.
package mcp3008_emulator_pkg;

    localparam int MCP_CMD_BITS  = 4;
    localparam int MCP_DATA_BITS = 10;
    localparam int MCP_NUM_CH    = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ST,
        CMD,
        SAMPLE,
        DATA,
        TAIL
    } state_t;

    // Pseudo-differential result: a negative difference reads as zero.
    function automatic logic [MCP_DATA_BITS-1:0] diff_clamp(
        input logic [MCP_DATA_BITS-1:0] p,
        input logic [MCP_DATA_BITS-1:0] m
    );
        logic [MCP_DATA_BITS:0] d;
        d = {1'b0, p} - {1'b0, m};
        return d[MCP_DATA_BITS] ? '0 : d[MCP_DATA_BITS-1:0];
    endfunction

endpackage

// File: rtl/mcp3008_emulator_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-clk rise and
// fall pulses derived from the synchronized level.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = lvl_o & ~prev_q;
    assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/mcp3008_emulator.sv
// MCP3008 8-channel 10-bit ADC emulator on the SPI responder side.
// Optional build macro MCP3008_EMU_LSB_TAIL_EN: repeat B1..B9 LSB-first after B0.
module mcp3008_emulator
    import mcp3008_emulator_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [9:0]  RESET_CODE  = 10'h000,
    parameter int          COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dclk,
    input  logic               cs_n,
    input  logic               din,
    output logic               dout,
    output logic               dout_oe,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [9:0]         wr_data,
    output logic [COUNT_W-1:0] conv_count,
    output logic [3:0]         last_cmd
);

    logic dclk_lvl, d_rise, d_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic din_lvl, din_rise, din_fall;

    // cs_n synchronizer resets low so a select already held low at reset release
    // is not mistaken for a fresh frame start.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dclk (
        .clk(clk), .rst_n(rst_n), .a_i(dclk), .lvl_o(dclk_lvl), .rise_o(d_rise), .fall_o(d_fall));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .a_i(cs_n), .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .a_i(din), .lvl_o(din_lvl), .rise_o(din_rise), .fall_o(din_fall));

    logic unused_edges;
    assign unused_edges = dclk_lvl ^ cs_rise ^ din_rise ^ din_fall;

    logic [9:0] ch_q [MCP_NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MCP_NUM_CH; i++) ch_q[i] <= RESET_CODE;
        end else if (wr_en) begin
            ch_q[wr_addr] <= wr_data;
        end
    end

    state_t             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [3:0]         last_cmd_q, last_cmd_d;
    logic [9:0]         word_q, word_d;
    logic               dout_q, dout_d;
    logic               oe_q, oe_d;
    logic [COUNT_W-1:0] conv_q, conv_d;
    logic [9:0]         sel_code;
    logic [3:0]         data_idx, tail_idx;

    assign sel_code = last_cmd_q[3] ? ch_q[last_cmd_q[2:0]]
                    : diff_clamp(ch_q[last_cmd_q[2:0]], ch_q[{last_cmd_q[2:1], ~last_cmd_q[0]}]);
    assign data_idx = 4'd9 - bit_cnt_q;
    assign tail_idx = bit_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            last_cmd_q <= '0;
            dout_q     <= 1'b0;
            oe_q       <= 1'b0;
            conv_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            last_cmd_q <= last_cmd_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            conv_q     <= conv_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        last_cmd_d = last_cmd_q;
        word_d     = word_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        conv_d     = conv_q;
        if (cs_lvl) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            dout_d    = 1'b0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = WAIT_ST;
                WAIT_ST: if (d_rise && din_lvl) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
                CMD: if (d_rise) begin
                    cmd_d     = {cmd_q[1:0], din_lvl};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd3) begin
                        last_cmd_d = {cmd_q, din_lvl};
                        state_d    = SAMPLE;
                        bit_cnt_d  = '0;
                    end
                end
                // Phase 0: skip the sample-period F; 1: latch on R; 2: null bit on F.
                SAMPLE: begin
                    if (bit_cnt_q == 4'd0 && d_fall) begin
                        bit_cnt_d = 4'd1;
                    end else if (bit_cnt_q == 4'd1 && d_rise) begin
                        word_d    = sel_code;
                        bit_cnt_d = 4'd2;
                    end else if (bit_cnt_q == 4'd2 && d_fall) begin
                        oe_d      = 1'b1;
                        dout_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: if (d_fall) begin
                    dout_d    = word_q[data_idx];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        conv_d    = conv_q + COUNT_W'(1);
                        bit_cnt_d = '0;
                        state_d   = TAIL;
                    end
                end
                TAIL: if (d_fall) begin
`ifdef MCP3008_EMU_LSB_TAIL_EN
                    if (bit_cnt_q < 4'd9) begin
                        dout_d    = word_q[tail_idx];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        dout_d = 1'b0;
                    end
`else
                    dout_d = 1'b0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_oe    = oe_q;
    assign conv_count = conv_q;
    assign last_cmd   = last_cmd_q;

    logic unused_tail;
    assign unused_tail = ^tail_idx;

endmodule
